// File: rtl/nvm_arb_if.sv
// nvm_arb_if: request/grant and NVM handshake bundle between requesters and the NVM arbiter.
`default_nettype none

interface nvm_arb_if;
  logic [2:0] req;
  logic       mem_done;
  logic       tag_status;
  logic [2:0] gnt;
  logic       mem_start;
  logic       mem_busy;
  logic [2:0] ack;
  logic       tout_err;

  modport master (
    output req, mem_done, tag_status,
    input  gnt, mem_start, mem_busy, ack, tout_err
  );

  modport slave (
    input  req, mem_done, tag_status,
    output gnt, mem_start, mem_busy, ack, tout_err
  );
endinterface

`default_nettype wire

// File: rtl/nvm_arb.sv
// ============================================================================
// nvm_arb : round-robin NVM access arbiter with timeout release and tag kill
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module nvm_arb #(
  parameter int TOUT_W   = 8,
  parameter int TOUT_MAX = 200
) (
  input  wire logic pmu_clk,
  input  wire logic rst_n,
  nvm_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    REL   = 2'd3
  } state_t;

  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_MAX - 1);

  state_t            state_q, state_d;
  logic [1:0]        last_owner_q, last_owner_d;
  logic [TOUT_W-1:0] count_q, count_d;
  logic              armed_q;

  logic [2:0]        gnt_q, gnt_d;
  logic              mem_start_q, mem_start_d;
  logic              mem_busy_q, mem_busy_d;
  logic [2:0]        ack_q, ack_d;
  logic              tout_err_q, tout_err_d;

  logic [3:0]        req_ext;
  logic [1:0]        cand1, cand2;
  logic [1:0]        winner;
  logic              found;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    next_idx = (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    onehot = 3'b001 << i;
  endfunction

  // Search order starts one past the previous owner, previous owner last.
  always_comb begin
    req_ext = {1'b0, bus.req};
    cand1   = next_idx(last_owner_q);
    cand2   = next_idx(cand1);
    winner  = last_owner_q;
    found   = 1'b0;
    if (req_ext[cand1]) begin
      winner = cand1;
      found  = 1'b1;
    end else if (req_ext[cand2]) begin
      winner = cand2;
      found  = 1'b1;
    end else if (req_ext[last_owner_q]) begin
      winner = last_owner_q;
      found  = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    count_d      = count_q;
    gnt_d        = gnt_q;
    mem_start_d  = 1'b0;
    mem_busy_d   = mem_busy_q;
    ack_d        = 3'b000;
    tout_err_d   = 1'b0;

    if (bus.tag_status) begin
      state_d    = IDLE;
      gnt_d      = 3'b000;
      mem_busy_d = 1'b0;
      count_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // armed_q holds off the very first edge after reset release
          if (armed_q && found) begin
            state_d      = GRANT;
            gnt_d        = onehot(winner);
            mem_start_d  = 1'b1;
            mem_busy_d   = 1'b1;
            count_d      = '0;
            last_owner_d = winner;
          end
        end
        GRANT: begin
          state_d = BUSY;
          count_d = '0;
        end
        BUSY: begin
          if (bus.mem_done) begin
            state_d    = REL;
            gnt_d      = 3'b000;
            mem_busy_d = 1'b0;
            ack_d      = onehot(last_owner_q);
            count_d    = '0;
          end else if (count_q == TOUT_LAST) begin
            state_d    = REL;
            gnt_d      = 3'b000;
            mem_busy_d = 1'b0;
            tout_err_d = 1'b1;
            count_d    = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        REL: begin
          state_d = IDLE;
        end
        default: begin
          state_d    = IDLE;
          gnt_d      = 3'b000;
          mem_busy_d = 1'b0;
          count_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge pmu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= 2'd2;
      count_q      <= '0;
      armed_q      <= 1'b0;
      gnt_q        <= 3'b000;
      mem_start_q  <= 1'b0;
      mem_busy_q   <= 1'b0;
      ack_q        <= 3'b000;
      tout_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      count_q      <= count_d;
      armed_q      <= 1'b1;
      gnt_q        <= gnt_d;
      mem_start_q  <= mem_start_d;
      mem_busy_q   <= mem_busy_d;
      ack_q        <= ack_d;
      tout_err_q   <= tout_err_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.mem_start = mem_start_q;
  assign bus.mem_busy  = mem_busy_q;
  assign bus.ack       = ack_q;
  assign bus.tout_err  = tout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_nvm_arb.sv
// tb_nvm_arb: directed and randomized checks of nvm_arb against a transaction-level arbitration model.
`default_nettype none

module tb_nvm_arb;
  localparam int TW = 5;
  localparam int TM = 20;

  logic pmu_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   last    = 2;

  nvm_arb_if bus();

  nvm_arb #(.TOUT_W(TW), .TOUT_MAX(TM)) dut (
    .pmu_clk (pmu_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 pmu_clk = ~pmu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pmu_clk);
    #1;
  endtask

  // Round-robin rule: first set request after the previous owner, wrapping.
  function automatic int pick(input logic [2:0] r, input int l);
    for (int k = 1; k <= 3; k++)
      if (r[(l + k) % 3]) return (l + k) % 3;
    return 0;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"},   bus.gnt, 0);
    chk({tag, "_busy"},  bus.mem_busy, 0);
    chk({tag, "_start"}, bus.mem_start, 0);
    chk({tag, "_ack"},   bus.ack, 0);
    chk({tag, "_tout"},  bus.tout_err, 0);
  endtask

  // One access from IDLE: grant, d BUSY cycles before mem_done, release, guard cycle.
  task automatic access(input logic [2:0] r, input int d, input bit drop, input bit early);
    int w;
    int busy_cycles;
    bus.req = r;
    w = pick(r, last);
    tick();
    chk("grant",       bus.gnt, 3'b001 << w);
    chk("grant_start", bus.mem_start, 1);
    chk("grant_busy",  bus.mem_busy, 1);
    bus.mem_done = early;
    tick();
    bus.mem_done = 1'b0;
    busy_cycles = 0;
    for (int j = 0; j < TM; j++) begin
      chk("hold_gnt",   bus.gnt, 3'b001 << w);
      chk("hold_busy",  bus.mem_busy, 1);
      chk("hold_start", bus.mem_start, 0);
      chk("hold_resp",  {bus.ack, bus.tout_err}, 0);
      if (drop && j == 0) bus.req[w] = 1'b0;
      bus.mem_done = (j == d);
      tick();
      bus.mem_done = 1'b0;
      busy_cycles++;
      if (j == d) break;
    end
    chk("rel_gnt",  bus.gnt, 0);
    chk("rel_busy", bus.mem_busy, 0);
    if (d <= TM - 1) begin
      chk("rel_ack",  bus.ack, 3'b001 << w);
      chk("rel_tout", bus.tout_err, 0);
    end else begin
      chk("rel_ack",        bus.ack, 0);
      chk("rel_tout",       bus.tout_err, 1);
      chk("tout_latency",   busy_cycles, TM);
    end
    last = w;
    bus.req = bus.req & ~(3'b001 << w);
    tick();
    chk_quiet("guard");
  endtask

  initial begin
    int w;
    bus.req        = 3'b000;
    bus.mem_done   = 1'b0;
    bus.tag_status = 1'b0;
    #2;
    chk_quiet("reset");

    repeat (2) @(posedge pmu_clk);
    #1;
    rst_n   = 1'b1;
    bus.req = 3'b111;
    tick();
    chk("first_edge_gnt", bus.gnt, 0);

    // Full rotation with all three requesting.
    repeat (4) access(3'b111, 4, 1'b0, 1'b0);

    // Quiet IDLE with stray mem_done.
    bus.req = 3'b000;
    repeat (3) begin
      bus.mem_done = 1'b1;
      tick();
      bus.mem_done = 1'b0;
      chk_quiet("idle");
    end

    access(3'b010, TM + 5, 1'b0, 1'b0);  // timeout
    access(3'b010, TM - 1, 1'b0, 1'b0);  // done coincident with last count
    access(3'b001, 3, 1'b1, 1'b0);       // owner drops request
    access(3'b100, 2, 1'b0, 1'b1);       // mem_done in GRANT ignored

    // Tag kill during an OCU access.
    bus.req = 3'b100;
    w = pick(3'b100, last);
    tick();
    chk("tag_pre_gnt", bus.gnt, 3'b001 << w);
    last = w;
    tick();
    tick();
    bus.tag_status = 1'b1;
    bus.req        = 3'b111;
    tick();
    chk_quiet("tag_kill");
    repeat (5) begin
      tick();
      chk_quiet("tag_hold");
    end
    bus.tag_status = 1'b0;
    bus.req        = 3'b000;
    tick();
    chk_quiet("tag_off");
    access(3'b100, TM + 2, 1'b0, 1'b0);
    access(3'b111, 1, 1'b0, 1'b0);

    // Asynchronous reset mid-access.
    bus.req = 3'b001;
    w = pick(3'b001, last);
    tick();
    chk("rst_pre_gnt", bus.gnt, 3'b001 << w);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_quiet("async_rst");
    last = 2;
    tick();
    tick();
    rst_n   = 1'b1;
    bus.req = 3'b110;
    tick();
    chk("rst_rel_gnt", bus.gnt, 0);
    access(3'b110, 2, 1'b0, 1'b0);

    // Randomized traffic.
    repeat (40) begin
      int d;
      if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, TM + 3));
      else                           d = int'($urandom_range(0, 6));
      access(3'($urandom_range(1, 7)), d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
